// File: rtl/regdst_pkg.sv
// regdst_pipe shared types and helpers.
// Address width, depth limit and the per-stage match function.
package regdst_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int MAX_DEPTH  = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Callers zero-extend to 32 bits, so any WIDTH up to 32 works.
  function automatic logic stage_match(
    input logic [31:0] addr,
    input logic        valid,
    input logic [31:0] src
  );
    return valid && (addr == src);
  endfunction

endpackage

// File: rtl/regdst_if.sv
// regdst_pipe port bundle.
// The master modport drives select/control, the slave returns stage state.
interface regdst_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 3
) ();

  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [WIDTH-1:0]        src_a;
  logic [WIDTH-1:0]        src_b;
  logic [DEPTH*WIDTH-1:0]  stage_addr;
  logic [DEPTH-1:0]        stage_valid;
  logic [WIDTH-1:0]        wb_addr;
  logic                    wb_valid;
  logic                    hazard_a;
  logic                    hazard_b;
  logic [2:0]              fwd_stage_a;
  logic [2:0]              fwd_stage_b;

  modport master (
    output sel, in_bus, in_valid, stall, flush, src_a, src_b,
    input  stage_addr, stage_valid, wb_addr, wb_valid,
    input  hazard_a, hazard_b, fwd_stage_a, fwd_stage_b
  );

  modport slave (
    input  sel, in_bus, in_valid, stall, flush, src_a, src_b,
    output stage_addr, stage_valid, wb_addr, wb_valid,
    output hazard_a, hazard_b, fwd_stage_a, fwd_stage_b
  );

endinterface

// File: rtl/regdst_stage.sv
// One pipeline register holding a destination address and its valid.
// Priority: reset, then flush (drop valid, keep addr), then stall.
module regdst_stage #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_addr,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_addr,
  output logic             q_valid
);

  // Address/valid register with reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_addr  <= '0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (!stall) begin
      q_addr  <= d_addr;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/regdst_pipe.sv
// Destination-register select plus DEPTH-stage shift and hazard match.
// Optional macro REGDST_ZERO_SUPPRESS_EN treats address 0 as $zero.
module regdst_pipe
  import regdst_pkg::*;
#(
  parameter int WIDTH  = REG_ADDR_W,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 3
) (
  input logic     clk,
  input logic     reset,
  regdst_if.slave bus
);

  logic [WIDTH-1:0] mux_out;
  logic             cap_valid;
  logic             src_a_ok;
  logic             src_b_ok;

  logic [WIDTH-1:0] s_addr  [DEPTH];
  logic             s_valid [DEPTH];
  logic [DEPTH-1:0] hit_a;
  logic [DEPTH-1:0] hit_b;

  // Lane select; out-of-range selects fall back to lane 0.
  always_comb begin
    mux_out = bus.in_bus[WIDTH-1:0];
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        mux_out = bus.in_bus[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef REGDST_ZERO_SUPPRESS_EN
  assign cap_valid = bus.in_valid && (mux_out != '0);
  assign src_a_ok  = (bus.src_a != '0);
  assign src_b_ok  = (bus.src_b != '0);
`else
  assign cap_valid = bus.in_valid;
  assign src_a_ok  = 1'b1;
  assign src_b_ok  = 1'b1;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_addr;
    logic             d_valid;

    if (k == 0) begin : g_head
      assign d_addr  = mux_out;
      assign d_valid = cap_valid;
    end else begin : g_tail
      assign d_addr  = s_addr[k-1];
      assign d_valid = s_valid[k-1];
    end

    regdst_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .stall   (bus.stall),
      .flush   (bus.flush),
      .d_addr  (d_addr),
      .d_valid (d_valid),
      .q_addr  (s_addr[k]),
      .q_valid (s_valid[k])
    );

    assign bus.stage_addr[k*WIDTH +: WIDTH] = s_addr[k];
    assign bus.stage_valid[k] = s_valid[k];

    assign hit_a[k] = src_a_ok && stage_match(
      32'(s_addr[k]), s_valid[k], 32'(bus.src_a));
    assign hit_b[k] = src_b_ok && stage_match(
      32'(s_addr[k]), s_valid[k], 32'(bus.src_b));
  end

  assign bus.wb_addr  = s_addr[DEPTH-1];
  assign bus.wb_valid = s_valid[DEPTH-1];

  // Scan oldest to youngest so the youngest producer is kept.
  always_comb begin
    bus.hazard_a    = 1'b0;
    bus.hazard_b    = 1'b0;
    bus.fwd_stage_a = '0;
    bus.fwd_stage_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_a[k]) begin
        bus.hazard_a    = 1'b1;
        bus.fwd_stage_a = 3'(k);
      end
      if (hit_b[k]) begin
        bus.hazard_b    = 1'b1;
        bus.fwd_stage_b = 3'(k);
      end
    end
  end

endmodule

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the 4:1 register-address selector.
- Selects one of NUM_IN destination-register addresses and carries it, with a valid bit, through a DEPTH-stage shift pipeline (EX/MEM/WB).
- Provides per-stage addresses and combinational source-operand hazard/forwarding match outputs for the datapath and control unit.
- Sits between instruction decode and the register-file write port.

Parameters:
- WIDTH, 5, bits per register address.
- NUM_IN, 4, number of selectable address inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEPTH, 3, pipeline stages from select to write-back (1..8).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  SEL_W  input select; lane i occupies in_bus[i*WIDTH +: WIDTH].
- in_bus  in  NUM_IN*WIDTH  flattened candidate addresses.
- in_valid  in  1  the selected address is a real write destination this cycle.
- stall  in  1  hold all stages.
- flush  in  1  invalidate all stages.
- src_a  in  WIDTH  decode-stage source operand A address.
- src_b  in  WIDTH  decode-stage source operand B address.
- stage_addr  out  DEPTH*WIDTH  registered address per stage; stage 0 is youngest.
- stage_valid  out  DEPTH  registered valid per stage.
- wb_addr  out  WIDTH  alias of stage DEPTH-1 address.
- wb_valid  out  1  alias of stage DEPTH-1 valid.
- hazard_a  out  1  src_a matches any valid stage.
- hazard_b  out  1  src_b matches any valid stage.
- fwd_stage_a  out  3  index of the youngest matching stage for A; 0 if none.
- fwd_stage_b  out  3  index of the youngest matching stage for B; 0 if none.

Behaviour:
- Reset: on a rising clk edge with reset=1, every stage_addr and stage_valid clears to 0. wb_addr and wb_valid are therefore 0. Reset overrides stall and flush. Reset mid-stream discards all in-flight entries.
- Select: combinational. mux_out = lane sel when sel < NUM_IN; lane 0 when sel >= NUM_IN (no X propagation).
- Advance (stall=0, flush=0):
  - stage0 <= {mux_out, in_valid}.
  - stage k <= stage k-1 for k = 1..DEPTH-1.
- Latency: an address selected in cycle t appears on wb_addr/wb_valid at the edge ending cycle t+DEPTH-1, i.e. DEPTH edges after capture.
- Stall (stall=1, flush=0): all stages hold both addresses and valids. in_valid is ignored that cycle.
- Flush (flush=1): all stage_valid bits clear to 0 and addresses are held. Flush wins over stall. in_valid is ignored that cycle.
- Flush does not alter the combinational hazard outputs in its own cycle; they reflect pre-edge state.
- Hazard match:
  - hazard_x = OR over k of (stage_valid[k] && stage_addr[k] == src_x).
  - fwd_stage_x = smallest matching k (youngest producer wins); 0 when no match.
  - The outputs are purely combinational from the registers and src ports, with zero latency.
- DEPTH=1: single register; wb equals stage0.
- No arithmetic; all compares are WIDTH-bit equality.

Optional Feature:
- Macro: REGDST_ZERO_SUPPRESS_EN.
- Defined:
  - an entry whose captured address is 0 gets valid forced to 0 on capture;
  - src_x == 0 never raises hazard_x, and fwd_stage_x = 0 in that case.
  - This models the MIPS hard-wired $zero.
- Undefined: address 0 is treated like any other register, both for valid capture and for hazard match.

Decomposition:
- Shared package regdst_pkg holds:
  - constant REG_ADDR_W = 5;
  - constant MAX_DEPTH = 8;
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]);
  - function stage_match(addr, valid, src) returning 1 bit.
- One sub-module: regdst_stage, a single register holding address and valid, with stall/flush/reset priority. It is instantiated DEPTH times in a generate loop.
- Selection and hazard logic stay in the top level.

Test Plan:
1. Reset with stale values: stages hold non-zero values, assert reset 1 cycle -> all stage_valid=0, stage_addr=0, wb_valid=0, hazard_a=hazard_b=0.
2. Latency and lane select (DEPTH=3, NUM_IN=4): lanes {5'd8, 5'd31, 5'd17, 5'd2}, sel=2'b10, in_valid=1 for 1 cycle -> wb_addr=17 and wb_valid=1 exactly 3 edges later, for one cycle.
3. Stall then flush: fill stages with 3, 4, 5; stall 2 cycles -> contents unchanged. Then flush+stall together 1 cycle -> all valid=0, addresses still 3, 4, 5.
4. Youngest-producer priority: stages hold 9 (stage0), 9 (stage1), 7 (stage2), all valid; src_a=9, src_b=7 -> hazard_a=1, fwd_stage_a=0; hazard_b=1, fwd_stage_b=2.
5. Out-of-range select (NUM_IN=3, SEL_W=2): sel=2'b11 with lane0=12 -> stage0 captures 12.
6. Zero register: capture addr 0 with in_valid=1, src_a=0. With REGDST_ZERO_SUPPRESS_EN -> stage0 valid=0, hazard_a=0. Without the macro -> stage0 valid=1, hazard_a=1, fwd_stage_a=0.
